// File: rtl/pcg_write_queue_if.sv
// Bus bundle for pcg_write_queue: Z80 OUT strobes in, CG RAM write cycle and FIFO status out.
// master = host/Z80 side driving the inputs, slave = the write queue itself.
interface pcg_write_queue_if #(
  parameter int unsigned ADDR_W = 11
);
  logic              i_nIORQ;
  logic              i_nWR;
  logic [7:0]        i_ZA;
  logic [7:0]        i_ZD;
  logic              i_FETCH;
  logic              o_RAM_REQ;
  logic [ADDR_W-1:0] o_CA;
  logic [7:0]        o_CD;
  logic              o_nRAM_WR;
  logic              o_EMPTY;
  logic              o_FULL;
  logic              o_OVF;

  modport master (
    output i_nIORQ, i_nWR, i_ZA, i_ZD, i_FETCH,
    input  o_RAM_REQ, o_CA, o_CD, o_nRAM_WR, o_EMPTY, o_FULL, o_OVF
  );

  modport slave (
    input  i_nIORQ, i_nWR, i_ZA, i_ZD, i_FETCH,
    output o_RAM_REQ, o_CA, o_CD, o_nRAM_WR, o_EMPTY, o_FULL, o_OVF
  );
endinterface

// File: rtl/pcg_write_queue.sv
// Z80 OUT-port capture into a small {addr,data} FIFO, retired as CG RAM writes while display fetch is idle.
// Build option: define PCGW_AUTOINC_EN to post-increment the address after each accepted data write.
//
// state    | meaning
// S_IDLE   | no RAM cycle; o_CA/o_CD keep last value
// S_SETUP  | bus requested, FIFO head on o_CA/o_CD; abort if fetch returns
// S_STROBE | o_nRAM_WR low for one clock
// S_HOLD   | address/data held after the strobe; entry popped on exit
module pcg_write_queue #(
  parameter logic [7:0]  PORT_BASE = 8'h10,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_W    = 11
) (
  input  logic               i_CLK,
  input  logic               i_nRST,
  pcg_write_queue_if.slave   bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned ENT_W = ADDR_W + 8;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        sync_q;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] addr_post;
  logic              ovf_q, ovf_d;
  logic [ADDR_W-1:0] ca_q, ca_d;
  logic [7:0]        cd_q, cd_d;
  logic              ram_req_q, ram_req_d;
  logic              nram_wr_q, nram_wr_d;
  logic [ENT_W-1:0]  mem_q [DEPTH];
  logic [ENT_W-1:0]  head;

  logic strobe_raw;
  logic pulse;
  logic hit_lo, hit_hi, hit_data, hit_clr;
  logic full, empty;
  logic push, pop;

  // Two flops resynchronise the Z80 strobe, the third detects its rising edge.
  assign strobe_raw = ~bus.i_nIORQ & ~bus.i_nWR;
  assign pulse      = sync_q[1] & ~sync_q[2];

  assign hit_lo   = pulse && (bus.i_ZA == PORT_BASE);
  assign hit_hi   = pulse && (bus.i_ZA == (PORT_BASE + 8'd1));
  assign hit_data = pulse && (bus.i_ZA == (PORT_BASE + 8'd2));
  assign hit_clr  = pulse && (bus.i_ZA == (PORT_BASE + 8'd3));

  assign full  = (cnt_q == CNT_FULL);
  assign empty = (cnt_q == '0);
  assign push  = hit_data & ~full;
  assign pop   = (state_q == S_HOLD);
  assign head  = mem_q[rd_ptr_q];

`ifdef PCGW_AUTOINC_EN
  assign addr_post = addr_q + ADDR_W'(1);
`else
  assign addr_post = addr_q;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    ovf_d  = ovf_q;
    if (hit_lo) begin
      addr_d[7:0] = bus.i_ZD;
    end
    if (hit_hi) begin
      addr_d[ADDR_W-1:8] = bus.i_ZD[ADDR_W-9:0];
    end
    if (push) begin
      addr_d = addr_post;
    end
    if (hit_data && full) begin
      ovf_d = 1'b1;
    end
    if (hit_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    ca_d    = ca_q;
    cd_d    = cd_q;
    case (state_q)
      S_IDLE: begin
        if (!empty && !bus.i_FETCH) begin
          state_d      = S_SETUP;
          {ca_d, cd_d} = head;
        end
      end
      S_SETUP:  state_d = bus.i_FETCH ? S_IDLE : S_STROBE;
      S_STROBE: state_d = S_HOLD;
      S_HOLD:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // Strobe and request are registered from the next state so they leave the block glitch-free.
    ram_req_d = (state_d != S_IDLE);
    nram_wr_d = (state_d != S_STROBE);
  end

  always_ff @(posedge i_CLK or negedge i_nRST) begin
    if (!i_nRST) begin
      state_q   <= S_IDLE;
      sync_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      ovf_q     <= 1'b0;
      ca_q      <= '0;
      cd_q      <= '0;
      ram_req_q <= 1'b0;
      nram_wr_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[1:0], strobe_raw};
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      ovf_q     <= ovf_d;
      ca_q      <= ca_d;
      cd_q      <= cd_d;
      ram_req_q <= ram_req_d;
      nram_wr_q <= nram_wr_d;
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge i_CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {addr_q, bus.i_ZD};
    end
  end

  assign bus.o_RAM_REQ = ram_req_q;
  assign bus.o_CA      = ca_q;
  assign bus.o_CD      = cd_q;
  assign bus.o_nRAM_WR = nram_wr_q;
  assign bus.o_EMPTY   = empty;
  assign bus.o_FULL    = full;
  assign bus.o_OVF     = ovf_q;

endmodule

// File: tb/tb_pcg_write_queue.sv
// Bench for pcg_write_queue: stimulus updates a port-level model and an expected-write queue;
// a negedge monitor pops that queue on every RAM write strobe.
module tb_pcg_write_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [10:0] ca;
    logic [7:0]  cd;
  } wr_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [10:0] m_addr;
  logic        m_ovf;
  wr_t         exp_q[$];

  pcg_write_queue_if #(.ADDR_W(11)) bus ();

  pcg_write_queue #(
    .PORT_BASE (8'h10),
    .DEPTH     (DEPTH),
    .ADDR_W    (11)
  ) dut (
    .i_CLK  (clk),
    .i_nRST (rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.o_nRAM_WR === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual ca=%h cd=%h required no write", bus.o_CA, bus.o_CD);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_ca", 32'(bus.o_CA), 32'(e.ca));
        chk("wr_cd", 32'(bus.o_CD), 32'(e.cd));
        chk("wr_req", 32'(bus.o_RAM_REQ), 32'd1);
        chk("wr_fetch_idle", 32'(bus.i_FETCH), 32'd0);
      end
    end
  end

  // Port semantics: full means DEPTH entries not yet written (valid while fetch holds the bus).
  task automatic model_out(input logic [7:0] za, input logic [7:0] zd);
    case (za)
      8'h10: m_addr[7:0]  = zd;
      8'h11: m_addr[10:8] = zd[2:0];
      8'h12: begin
        if (exp_q.size() >= DEPTH) begin
          m_ovf = 1'b1;
        end else begin
          exp_q.push_back('{ca: m_addr, cd: zd});
`ifdef PCGW_AUTOINC_EN
          m_addr = m_addr + 11'd1;
`endif
        end
      end
      8'h13: m_ovf = 1'b0;
      default: ;
    endcase
  endtask

  task automatic out_wr(input logic [7:0] za, input logic [7:0] zd);
    model_out(za, zd);
    bus.i_ZA    = za;
    bus.i_ZD    = zd;
    bus.i_nIORQ = 1'b0;
    bus.i_nWR   = 1'b0;
    repeat (4) @(negedge clk);
    bus.i_nIORQ = 1'b1;
    bus.i_nWR   = 1'b1;
    @(negedge clk);
    bus.i_ZA = 8'($urandom);
    bus.i_ZD = 8'($urandom);
    repeat (2) @(negedge clk);
    chk("ovf", 32'(bus.o_OVF), 32'(m_ovf));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(negedge clk);
    chk("empty_after_drain", 32'(bus.o_EMPTY), 32'd1);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    m_addr      = '0;
    m_ovf       = 1'b0;
    rst_n       = 1'b0;
    bus.i_nIORQ = 1'b1;
    bus.i_nWR   = 1'b1;
    bus.i_ZA    = 8'h00;
    bus.i_ZD    = 8'h00;
    bus.i_FETCH = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_nwr",   32'(bus.o_nRAM_WR), 32'd1);
    chk("rst_req",   32'(bus.o_RAM_REQ), 32'd0);
    chk("rst_ca",    32'(bus.o_CA),      32'd0);
    chk("rst_cd",    32'(bus.o_CD),      32'd0);
    chk("rst_empty", 32'(bus.o_EMPTY),   32'd1);
    chk("rst_full",  32'(bus.o_FULL),    32'd0);
    chk("rst_ovf",   32'(bus.o_OVF),     32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic write: address 534, data A5.
    out_wr(8'h10, 8'h34);
    out_wr(8'h11, 8'h05);
    out_wr(8'h12, 8'hA5);
    drain();

    // Address wrap at the top of the RAM.
    out_wr(8'h10, 8'hFF);
    out_wr(8'h11, 8'hFF);
    out_wr(8'h12, 8'h01);
    out_wr(8'h12, 8'h02);
    drain();

    // Fill past capacity while fetch owns the bus.
    bus.i_FETCH = 1'b1;
    for (int i = 0; i < 5; i++) out_wr(8'h12, 8'(8'h40 + i));
    chk("full_full",  32'(bus.o_FULL),  32'd1);
    chk("full_ovf",   32'(bus.o_OVF),   32'd1);
    chk("full_empty", 32'(bus.o_EMPTY), 32'd0);
    chk("full_pending", 32'(exp_q.size()), 32'd4);
    bus.i_FETCH = 1'b0;
    drain();
    out_wr(8'h13, 8'h00);
    chk("ovf_cleared", 32'(bus.o_OVF), 32'd0);

    // Fetch returns during SETUP: cycle aborted, entry retained.
    bus.i_FETCH = 1'b1;
    out_wr(8'h12, 8'h3C);
    bus.i_FETCH = 1'b0;
    @(negedge clk);
    chk("abort_setup_req", 32'(bus.o_RAM_REQ), 32'd1);
    chk("abort_setup_ca", 32'(bus.o_CA), 32'(exp_q[0].ca));
    bus.i_FETCH = 1'b1;
    @(negedge clk);
    chk("abort_req", 32'(bus.o_RAM_REQ), 32'd0);
    chk("abort_nwr", 32'(bus.o_nRAM_WR), 32'd1);
    chk("abort_empty", 32'(bus.o_EMPTY), 32'd0);
    repeat (5) @(negedge clk);
    chk("abort_kept", 32'(exp_q.size()), 32'd1);
    bus.i_FETCH = 1'b0;
    drain();

    // Push lands on the same edge as the HOLD->IDLE pop.
    bus.i_FETCH = 1'b1;
    out_wr(8'h12, 8'h11);
    bus.i_FETCH = 1'b0;
    @(negedge clk);
    model_out(8'h12, 8'h22);
    bus.i_ZA    = 8'h12;
    bus.i_ZD    = 8'h22;
    bus.i_nIORQ = 1'b0;
    bus.i_nWR   = 1'b0;
    repeat (3) @(negedge clk);
    chk("pp_empty", 32'(bus.o_EMPTY), 32'd0);
    chk("pp_full",  32'(bus.o_FULL),  32'd0);
    chk("pp_idle",  32'(bus.o_RAM_REQ), 32'd0);
    @(negedge clk);
    chk("pp_next_req", 32'(bus.o_RAM_REQ), 32'd1);
    chk("pp_next_cd",  32'(bus.o_CD), 32'h22);
    bus.i_nIORQ = 1'b1;
    bus.i_nWR   = 1'b1;
    drain();

    // Randomized traffic, alternating fetch-blocked bursts and free-running writes.
    for (int r = 0; r < 10; r++) begin
      int  n;
      bit  blocked;
      blocked = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 6);
      bus.i_FETCH = blocked;
      for (int k = 0; k < n; k++) begin
        logic [7:0] za;
        int sel;
        sel = $urandom_range(0, 7);
        case (sel)
          0:       za = 8'h10;
          1:       za = 8'h11;
          5:       za = 8'h13;
          6:       za = 8'($urandom);
          default: za = 8'h12;
        endcase
        out_wr(za, 8'($urandom));
        if (blocked) begin
          chk("rnd_full",  32'(bus.o_FULL),  32'(exp_q.size() >= DEPTH));
          chk("rnd_empty", 32'(bus.o_EMPTY), 32'(exp_q.size() == 0));
        end
      end
      bus.i_FETCH = 1'b0;
      drain();
    end

    // Reset asserted in the middle of a write strobe.
    bus.i_FETCH = 1'b1;
    out_wr(8'h12, 8'h55);
    out_wr(8'h12, 8'h66);
    bus.i_FETCH = 1'b0;
    begin
      bit found;
      found = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
        @(negedge clk);
        if (bus.o_nRAM_WR === 1'b0) found = 1'b1;
      end
      chk("rst_strobe_seen", 32'(found), 32'd1);
    end
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_nwr",   32'(bus.o_nRAM_WR), 32'd1);
    chk("mid_rst_empty", 32'(bus.o_EMPTY),   32'd1);
    chk("mid_rst_req",   32'(bus.o_RAM_REQ), 32'd0);
    chk("mid_rst_ca",    32'(bus.o_CA),      32'd0);
    exp_q.delete();
    m_addr = '0;
    m_ovf  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_empty", 32'(bus.o_EMPTY), 32'd1);
    out_wr(8'h12, 8'h77);
    drain();

    chk("final_pending", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
